// File: rtl/multiplier_core_pkg.sv
// Shared constants and width helpers for the array multiplier.
package multiplier_core_pkg;

    localparam int unsigned DEFAULT_WIDTH = 2;

    function automatic int unsigned product_width(input int unsigned width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/multiplier_core_if.sv
// Operand/result bundle between an operand source and the multiplier core.
interface multiplier_core_if
    import multiplier_core_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    localparam int unsigned PW = product_width(WIDTH);

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [PW-1:0]    product;

    modport master (output in_valid, a, b, input out_valid, product);
    modport slave  (input in_valid, a, b, output out_valid, product);

endinterface

// File: rtl/multiplier_core_pp_adder_row.sv
// One reduction row: adds a partial-product vector to the previous row's upper
// sum bits and carry (the previous LSB has already retired into the product).
module pp_adder_row #(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-2:0] prev_sum,
    input  logic             prev_carry,
    input  logic [WIDTH-1:0] pp,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    // Ripple-carry chain of full adders
    always_comb begin
        acc  = {prev_carry, prev_sum};
        c    = '0;
        s    = '0;
        c[0] = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            s[k]   = acc[k] ^ pp[k] ^ c[k];
            c[k+1] = (acc[k] & pp[k]) | (c[k] & (acc[k] ^ pp[k]));
        end
    end

    assign sum       = s;
    assign carry_out = c[WIDTH];

endmodule

// File: rtl/multiplier_core.sv
// Unsigned WIDTH x WIDTH array multiplier with a single registered output stage.
module multiplier_core
    import multiplier_core_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    multiplier_core_if.slave   bus
);

    localparam int unsigned PW = product_width(WIDTH);

    logic [WIDTH-1:0] pp [WIDTH];
    logic [PW-1:0]    prod_comb;

    // AND array: row i is a gated by b[i]
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pp[i] = bus.a & {WIDTH{bus.b[i]}};
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_row
        logic [WIDTH-1:0] sum;
        logic             carry;

        if (i == 0) begin : g_first
            assign sum   = pp[0];
            assign carry = 1'b0;
        end else begin : g_add
            pp_adder_row #(
                .WIDTH(WIDTH)
            ) u_row (
                .prev_sum   (g_row[i-1].sum[WIDTH-1:1]),
                .prev_carry (g_row[i-1].carry),
                .pp         (pp[i]),
                .sum        (sum),
                .carry_out  (carry)
            );
        end

        assign prod_comb[i] = sum[0];
    end

    // Final row supplies the upper half
    assign prod_comb[PW-1:WIDTH] = {g_row[WIDTH-1].carry, g_row[WIDTH-1].sum[WIDTH-1:1]};

    // Output register only loads on valid operands, so idle inputs never reach product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.product   <= '0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.product <= prod_comb;
            end
        end
    end

endmodule

// File: tb/tb_multiplier_core.sv
// Scoreboard bench for multiplier_core at WIDTH=2 and WIDTH=4 side by side.
module tb_multiplier_core;

    logic clk;
    logic rst;

    multiplier_core_if #(.WIDTH(2)) bus2 ();
    multiplier_core_if #(.WIDTH(4)) bus4 ();

    multiplier_core #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    multiplier_core #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int unsigned exp_prod [2][$];
    int          exp_due  [2][$];
    int unsigned held     [2];

    // Reference: plain integer product of operands reduced to the DUT width
    task automatic step(input bit v2, input int unsigned a2, input int unsigned b2,
                        input bit v4, input int unsigned a4, input int unsigned b4);
        @(negedge clk);
        bus2.in_valid = v2;
        bus2.a        = 2'(a2);
        bus2.b        = 2'(b2);
        bus4.in_valid = v4;
        bus4.a        = 4'(a4);
        bus4.b        = 4'(b4);
        if (v2) begin
            exp_prod[0].push_back((a2 % 4) * (b2 % 4));
            exp_due[0].push_back(cyc + 1);
        end
        if (v4) begin
            exp_prod[1].push_back((a4 % 16) * (b4 % 16));
            exp_due[1].push_back(cyc + 1);
        end
    endtask

    task automatic flush_model();
        for (int d = 0; d < 2; d++) begin
            exp_prod[d].delete();
            exp_due[d].delete();
            held[d] = 0;
        end
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if (bus2.out_valid !== 1'b0 || bus2.product !== 4'd0) begin
            errors++;
            $display("FAIL %s w2: out_valid=%b product=%0d required 0/0", nm, bus2.out_valid, bus2.product);
        end
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.product !== 8'd0) begin
            errors++;
            $display("FAIL %s w4: out_valid=%b product=%0d required 0/0", nm, bus4.out_valid, bus4.product);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge
    initial begin
        logic        ov;
        logic [7:0]  pr;
        int unsigned ep;
        int          ed;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int d = 0; d < 2; d++) begin
                ov = (d == 0) ? bus2.out_valid : bus4.out_valid;
                pr = (d == 0) ? 8'(bus2.product) : bus4.product;
                if (ov === 1'b1) begin
                    checks++;
                    if (exp_prod[d].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out dut%0d cyc=%0d product=%0d required no output", d, cyc, pr);
                    end else begin
                        ep = exp_prod[d].pop_front();
                        ed = exp_due[d].pop_front();
                        held[d] = ep;
                        if (ed != cyc || pr !== 8'(ep)) begin
                            errors++;
                            $display("FAIL product dut%0d cyc=%0d got=%0d required=%0d (due cyc %0d)", d, cyc, pr, ep, ed);
                        end
                    end
                end else begin
                    checks++;
                    if (pr !== 8'(held[d])) begin
                        errors++;
                        $display("FAIL hold dut%0d cyc=%0d product=%0d required=%0d", d, cyc, pr, held[d]);
                    end
                    if (exp_due[d].size() > 0 && exp_due[d][0] <= cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL missing_out dut%0d cyc=%0d out_valid=%b required 1 (product %0d)", d, cyc, ov, exp_prod[d][0]);
                        void'(exp_prod[d].pop_front());
                        void'(exp_due[d].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0;
        flush_model();
        #1;
        check_zero("reset_state");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed small cases, one per cycle
        step(1, 0, 0, 1, 15, 15);
        step(1, 0, 1, 1, 8, 2);
        step(1, 1, 0, 1, 0, 15);
        step(1, 1, 1, 0, 0, 0);
        step(1, 2, 2, 0, 0, 0);
        step(1, 3, 3, 0, 0, 0);

        // Hold: idle cycles with changing operands must not touch product
        step(0, 1, 2, 0, 5, 7);
        step(0, 1, 2, 0, 9, 3);
        step(0, 1, 2, 0, 2, 2);

        // Exhaustive WIDTH=2 back-to-back
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                step(1, a, b, 1, a * 5 + 1, b * 3 + 2);
        step(0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-cycle while out_valid is high
        step(1, 3, 3, 1, 15, 15);
        @(posedge clk);
        #3;
        rst = 1'b1;
        bus2.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        flush_model();
        #1;
        check_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 0);

        // Reset recovery: operand coinciding with reset is dropped
        @(negedge clk);
        rst = 1'b1;
        flush_model();
        bus2.in_valid = 1'b1; bus2.a = 2'd3; bus2.b = 2'd3;
        bus4.in_valid = 1'b1; bus4.a = 4'd12; bus4.b = 4'd11;
        @(negedge clk);
        rst = 1'b0;
        bus2.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        step(1, 2, 3, 1, 13, 7);
        step(0, 0, 0, 0, 0, 0);

        // Random traffic with random idle gaps
        for (int n = 0; n < 300; n++) begin
            step(bit'($urandom_range(0, 3) != 0), $urandom, $urandom,
                 bit'($urandom_range(0, 3) != 0), $urandom, $urandom);
        end
        step(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            checks++;
            if (exp_prod[d].size() != 0) begin
                errors++;
                $display("FAIL drain dut%0d pending=%0d required 0", d, exp_prod[d].size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multiplier_core.md
Name: multiplier_core

Overview:
- Unsigned integer multiplier: A (WIDTH bits) x B (WIDTH bits) -> full-precision product (2*WIDTH bits).
- Built as a partial-product AND array reduced by ripple-carry adder rows, followed by one output register stage.
- Sits as a leaf arithmetic block, fed by a valid-qualified operand pair; downstream logic consumes product qualified by out_valid.

Parameters:
- WIDTH, 2, operand width in bits; legal range 2..16. Product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair on a/b is valid this cycle
- a  input  WIDTH  multiplicand, unsigned
- b  input  WIDTH  multiplier, unsigned
- out_valid  output  1  product holds a new result this cycle
- product  output  2*WIDTH  registered unsigned product a*b

Behaviour:
- Reset: clk and an asynchronous, active-high rst; rst asserted forces product=0 and out_valid=0 immediately, independent of clk. Both stay at 0 while rst is held.
- Arithmetic: unsigned, exact, no truncation. Max result (2^WIDTH-1)^2 fits in 2*WIDTH bits, so no overflow case exists.
- Datapath:
  - Partial product pp[i][j] = a[j] & b[i].
  - Row 0 = pp[0].
  - Each subsequent row i adds pp[i] shifted left by i via a WIDTH-bit ripple-carry adder row.
  - Product bits fall out LSB-first from each row; the final row supplies the upper bits.
- Latency: 1 cycle.
  - in_valid=1 at edge N -> product=a*b and out_valid=1 after edge N.
  - Back-to-back valid operands give one result per cycle (full throughput).
- Hold: in_valid=0 at an edge -> out_valid=0, product keeps its last value. No change to product without in_valid.
- No back-pressure. Results are never stalled or queued.
- Reset mid-operation: an operand accepted at the edge coinciding with or preceding rst assertion is discarded. The first valid operand after rst deassertion produces a normal result one cycle later.
- X on a/b while in_valid=0 must not propagate into product.

Decomposition:
- Shared package: default WIDTH constant; a localparam/function for product width (2*WIDTH).
- One natural sub-module: pp_adder_row.
  - Parameterized WIDTH.
  - Takes the previous row's sum, its carry-out and a partial-product vector.
  - Produces WIDTH sum bits plus carry-out.
  - Instantiated WIDTH-1 times in a generate loop.
- Top holds AND array, row chaining and output register.

Test Plan:
- Reset: assert rst mid-cycle with out_valid=1 -> product=0 and out_valid=0 immediately, before next edge.
- Directed WIDTH=2, one operand per cycle with in_valid=1:
  - (0,0) -> 0000
  - (0,1) -> 0000
  - (1,0) -> 0000
  - (1,1) -> 0001
  - (2,2) -> 0100
  - (3,3) -> 1001
  - Each result appears one cycle after its operands.
- Exhaustive WIDTH=2: all 16 a/b pairs back-to-back -> out_valid high 16 consecutive cycles, each product equal to a*b; 3*2 -> 0110.
- Hold: valid (3,3), then in_valid=0 with a=1, b=2 for 3 cycles -> out_valid=0 and product stays 1001.
- Width scaling WIDTH=4: (15,15) -> 225 (11100001); (8,2) -> 16; (0,15) -> 0.
- Reset recovery: rst pulsed while in_valid=1 with (3,3) -> no 1001 emitted. Valid (2,3) one cycle after deassertion -> product 0110 with out_valid=1.
